// File: rtl/mem_access_unit.sv
// Data-memory access unit: a load/store port with a fixed-latency wait FSM,
// byte/half/word lanes with sign/zero extension, misalignment detection and
// branch resolution (PCSrc).
module mem_access_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic              Branch,
  input  logic              BranchNe,
  input  logic              zero,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [DATA_W-1:0] rfile_rd2,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              misalign,
  output logic              PCSrc
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          LANES = DATA_W / 8;
  localparam logic [3:0]  LAT4  = 4'(LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_addr, r_wdata, r_rdata;
  logic [1:0]          r_size;
  logic                r_uns, r_is_load, r_is_store, r_valid;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req, w_misal_in, w_accept, w_enter_done, w_idle;
  logic [DATA_W-1:0]   w_op_addr, w_op_data;
  logic [1:0]          w_op_size;
  logic                w_op_uns, w_op_load, w_op_store;
  logic [IDX_W-1:0]    w_idx;
  logic [LANES-1:0]    w_be;
  logic [DATA_W-1:0]   w_wdata;

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [LANES-1:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    logic [LANES-1:0] be;
    for (int l = 0; l < LANES; l++) begin
      case (sz)
        2'b00:   be[l] = ((l % 4) == int'(a));
        2'b01:   be[l] = (((l / 2) % 2) == int'(a[1]));
        default: be[l] = 1'b1;
      endcase
    end
    return be;
  endfunction

  // Store data replicated across lanes so any enabled lane sees the right bytes.
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    case (sz)
      2'b00:   return {LANES{d[7:0]}};
      2'b01:   return {(LANES/2){d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Right-justify the addressed lane(s) of a word and extend to DATA_W.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] a,
                                                    input logic [1:0] sz,
                                                    input logic uns);
    logic [DATA_W-1:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    case (sz)
      2'b00: begin
        sh = word >> {a, 3'b000};
        sb = sh[7:0];
        return uns ? DATA_W'(sh[7:0]) : DATA_W'(sb);
      end
      2'b01: begin
        sh  = word >> {a[1], 4'b0000};
        shw = sh[15:0];
        return uns ? DATA_W'(sh[15:0]) : DATA_W'(shw);
      end
      default: return word;
    endcase
  endfunction

  assign PCSrc      = Branch & (zero ^ BranchNe);
  assign w_idle     = (r_state == S_IDLE);
  assign w_req      = MemRead | MemWrite;
  assign w_misal_in = ((Size == 2'b01) && ALUout[0]) || (Size[1] && (ALUout[1:0] != 2'b00));
  assign misalign   = w_idle && w_req && w_misal_in;
  assign w_accept   = w_idle && w_req && !w_misal_in;
  assign stall      = w_accept || (r_state == S_WAIT);

  // With LAT=0 the access completes on the capture edge, so the operation
  // must come straight from the inputs while still in IDLE.
  assign w_op_addr  = w_idle ? ALUout    : r_addr;
  assign w_op_data  = w_idle ? rfile_rd2 : r_wdata;
  assign w_op_size  = w_idle ? Size      : r_size;
  assign w_op_uns   = w_idle ? Unsigned  : r_uns;
  assign w_op_load  = w_idle ? (MemRead & ~MemWrite) : r_is_load;
  assign w_op_store = w_idle ? MemWrite  : r_is_store;
  assign w_idx      = w_op_addr[IDX_W+1:2];
  assign w_be       = lane_en(w_op_size, w_op_addr[1:0]);
  assign w_wdata    = lane_data(w_op_size, w_op_data);

  // Next-state logic; flags the edge on which the access completes.
  always_comb begin
    w_next       = r_state;
    w_enter_done = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (LAT4 == 4'd0) begin
          w_next       = S_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: if (r_cnt == LAT4 - 4'd1) begin
        w_next       = S_DONE;
        w_enter_done = 1'b1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((r_state == S_WAIT) && !w_enter_done) ? r_cnt + 4'd1 : 4'd0;
    end
  end

  // Request capture; only meaningful after an accepted request.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr     <= ALUout;
      r_wdata    <= rfile_rd2;
      r_size     <= Size;
      r_uns      <= Unsigned;
      r_is_load  <= MemRead & ~MemWrite;
      r_is_store <= MemWrite;
    end
  end

  // Store commit on the edge entering DONE; an access aborted by reset never writes.
  always_ff @(posedge clk) begin
    if (rst && w_enter_done && w_op_store) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  // Load result register: holds the extended data only during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else if (w_enter_done && w_op_load) begin
      r_valid <= 1'b1;
      r_rdata <= load_extend(r_mem[w_idx], w_op_addr[1:0], w_op_size, w_op_uns);
    end else begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end
  end

  assign rdata_valid = r_valid;
  assign dmem_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (LAT=2, DEPTH=256) with an expected-data queue.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Unsigned, Branch, BranchNe, zero;
  logic [1:0]  Size;
  logic [31:0] ALUout, rfile_rd2, dmem_rdata;
  logic        rdata_valid, stall, misalign, PCSrc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  mem_access_unit #(.DATA_W(32), .DEPTH(256), .LAT(2)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Branch(Branch), .BranchNe(BranchNe), .zero(zero),
    .ALUout(ALUout), .rfile_rd2(rfile_rd2), .dmem_rdata(dmem_rdata),
    .rdata_valid(rdata_valid), .stall(stall), .misalign(misalign), .PCSrc(PCSrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: drive at negedge, hold while stalled, check DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [31:0] exp, input string tag);
    int cyc;
    bit done;
    logic [31:0] e;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; ALUout = addr; rfile_rd2 = wdat;
    #1;
    chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    if (rd && !wr) sb_q.push_back(exp);
    cyc  = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) cyc++;
      else done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_stall_cycles"}, 32'(cyc), 32'd3);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk({tag, "_valid"}, 32'(rdata_valid), 32'(rd && !wr));
    if (rd && !wr) begin
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
      chk({tag, "_data"}, dmem_rdata, e);
    end else begin
      chk({tag, "_data_zero"}, dmem_rdata, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_valid_after"}, 32'(rdata_valid), 32'd0);
  endtask

  task automatic misal(input logic [1:0] sz, input logic [31:0] addr, input string tag);
    @(negedge clk);
    MemRead = 1'b1; Size = sz; ALUout = addr; Unsigned = 1'b0;
    #1;
    chk({tag, "_misalign"}, 32'(misalign), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({tag, "_still_idle"}, 32'(misalign), 32'd1);
    chk({tag, "_no_valid"}, 32'(rdata_valid), 32'd0);
    MemRead = 1'b0;
    #1;
    chk({tag, "_misalign_clr"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    int cyc;
    bit done;
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b10; Unsigned = 1'b0;
    Branch = 1'b0; BranchNe = 1'b0; zero = 1'b0; ALUout = '0; rfile_rd2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rdata_valid), 32'd0);
    chk("rst_data", dmem_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b1;

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, "sw10");
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "lw10");

    // Branch resolution, including while the unit stalls.
    Branch = 1'b1; zero = 1'b1; BranchNe = 1'b0; #1 chk("pc_beq_taken", 32'(PCSrc), 32'd1);
    BranchNe = 1'b1; #1 chk("pc_bne_not", 32'(PCSrc), 32'd0);
    zero = 1'b0; #1 chk("pc_bne_taken", 32'(PCSrc), 32'd1);
    Branch = 1'b0; #1 chk("pc_nobranch", 32'(PCSrc), 32'd0);
    @(negedge clk);
    MemRead = 1'b1; Size = 2'b10; ALUout = 32'h10; Branch = 1'b0; zero = 1'b1; BranchNe = 1'b0;
    #1;
    chk("pcst_stall", 32'(stall), 32'd1);
    chk("pcst_nobranch", 32'(PCSrc), 32'd0);
    Branch = 1'b1; #1 chk("pcst_taken", 32'(PCSrc), 32'd1);
    @(negedge clk);
    chk("pcst_wait_stall", 32'(stall), 32'd1);
    chk("pcst_wait_taken", 32'(PCSrc), 32'd1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) chk("pcst_timeout", 32'd0, 32'd1);
    MemRead = 1'b0; Branch = 1'b0;
    chk("pcst_valid", 32'(rdata_valid), 32'd1);
    chk("pcst_data", dmem_rdata, 32'hDEADBEEF);
    @(negedge clk);

    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F, 32'h0, "sb11");
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, "lb11");
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, "lw10_merged");
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, "lh12");
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, "lhu12");
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, "lb10_sext");
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, "lw10_size11");

    misal(2'b01, 32'h13, "lh13");
    misal(2'b10, 32'h12, "lw12");
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, "lw10_unchanged");

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 32'h0, "sw400");
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12345678, "lw000_wrap");

    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D, 32'h0, "rw30_store");
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0BADF00D, "lw30");

    // Reset in the first WAIT cycle aborts the pending store.
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, 32'h0, "sw20_init");
    @(negedge clk);
    MemWrite = 1'b1; Size = 2'b10; ALUout = 32'h20; rfile_rd2 = 32'hAAAAAAAA;
    #1 chk("abort_stall", 32'(stall), 32'd1);
    @(negedge clk);
    chk("abort_in_wait", 32'(stall), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; MemWrite = 1'b0;
    #1;
    chk("abort_valid", 32'(rdata_valid), 32'd0);
    chk("abort_data", dmem_rdata, 32'd0);
    chk("abort_stall_clr", 32'(stall), 32'd0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11111111, "lw20_after_abort");

    chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
